// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDUCtrl operation encodings used by both the decoder and mdu_unit
//   - default busy-window lengths for multiply and divide
//   - controller state type and a helper classifying multi-cycle ops
package mdu_pkg;

    localparam logic [3:0] MDU_NOP   = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_t;

    // True for the operations that open a busy window (MULT/MULTU/DIV/DIVU).
    function automatic logic is_long_op(logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// mdu_unit: EX-stage multiply/divide unit holding architectural HI/LO.
// The arithmetic is combinational; the multi-cycle latency is modelled by
// a down-counter that keeps `busy` high for MULT_CYCLES / DIV_CYCLES cycles
// before the pending result is committed to HI/LO.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   start        in   launch request for MULT/MULTU/DIV/DIVU
//   MDUCtrl      in   operation code (mdu_pkg encodings; 7..15 = NOP)
//   MDUResultSel in   read-port select: 1 = HI, 0 = LO
//   A, B         in   rs / rt operands
//   busy         out  operation in flight (hazard unit stalls on it)
//   HI, LO       out  architectural HI/LO
//   MDUResult    out  MDUResultSel ? HI : LO (combinational)
//   dbg_state    out  controller state (0 = IDLE, 1 = RUN)
//
// Handshake: an op is accepted on a rising edge where start=1, MDUCtrl is a
// multi-cycle op and the unit is idle (busy=0). While busy=1, start and
// MTHI/MTLO are ignored; the hazard unit is responsible for not issuing them.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUCtrl,
    input  logic        MDUResultSel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUResult,
    output logic        dbg_state
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_REQ = $clog2(CNT_MAX + 1);
    localparam int CNT_W   = (CNT_REQ < 4) ? 4 : CNT_REQ;

    mdu_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       hi_p;
    logic [31:0]       lo_p;
    logic              wr_p;     // commit pending result (cleared on divide by zero)

    // Combinational result of the op currently presented on MDUCtrl/A/B.
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;
    logic              res_wr;
    logic [CNT_W-1:0]  res_cycles;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        div_b;
    logic               b_zero;
    logic               div_ovf;
    logic [31:0]        q_s, r_s, q_u, r_u;

    always_comb begin
        prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u  = {32'd0, A} * {32'd0, B};
        b_zero  = (B == 32'd0);
        // Substitute a divisor of 1 so the dividers never see zero; the
        // result is discarded in that case anyway.
        div_b   = b_zero ? 32'd1 : B;
        // The single signed overflow case: -2^31 / -1 wraps back to -2^31.
        div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        if (div_ovf) begin
            q_s = 32'h8000_0000;
            r_s = 32'd0;
        end else begin
            q_s = $signed(A) / $signed(div_b);
            r_s = $signed(A) % $signed(div_b);
        end
        q_u = A / div_b;
        r_u = A % div_b;

        res_hi     = 32'd0;
        res_lo     = 32'd0;
        res_wr     = 1'b1;
        res_cycles = CNT_W'(DIV_CYCLES);
        case (MDUCtrl)
            MDU_MULT: begin
                res_hi     = prod_s[63:32];
                res_lo     = prod_s[31:0];
                res_cycles = CNT_W'(MULT_CYCLES);
            end
            MDU_MULTU: begin
                res_hi     = prod_u[63:32];
                res_lo     = prod_u[31:0];
                res_cycles = CNT_W'(MULT_CYCLES);
            end
            MDU_DIV: begin
                res_hi = r_s;
                res_lo = q_s;
                res_wr = !b_zero;
            end
            MDU_DIVU: begin
                res_hi = r_u;
                res_lo = q_u;
                res_wr = !b_zero;
            end
            default: begin
                res_wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi_p  <= 32'd0;
            lo_p  <= 32'd0;
            wr_p  <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && is_long_op(MDUCtrl)) begin
                        hi_p  <= res_hi;
                        lo_p  <= res_lo;
                        wr_p  <= res_wr;
                        cnt   <= res_cycles;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else if (MDUCtrl == MDU_MTHI) begin
                        HI <= A;
                    end else if (MDUCtrl == MDU_MTLO) begin
                        LO <= A;
                    end
                end
                S_RUN: begin
                    cnt <= cnt - 1'b1;
                    // cnt was loaded with N at launch, so it reads 1 on the
                    // N-th edge after launch: busy spans exactly N cycles.
                    if (cnt == CNT_W'(1)) begin
                        if (wr_p) begin
                            HI <= hi_p;
                            LO <= lo_p;
                        end
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign MDUResult = MDUResultSel ? HI : LO;
    assign dbg_state = (state == S_RUN);

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: table of multi-cycle ops with hand-computed
// HI/LO and window lengths, plus sequences for divide by zero, MTHI/MTLO,
// asynchronous reset mid-operation and back-to-back launch.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  MDUCtrl;
    logic        MDUResultSel;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUResult;
    logic        dbg_state;

    int total;
    int bad;

    mdu_unit dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .MDUCtrl      (MDUCtrl),
        .MDUResultSel (MDUResultSel),
        .A            (A),
        .B            (B),
        .busy         (busy),
        .HI           (HI),
        .LO           (LO),
        .MDUResult    (MDUResult),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge: present the op, let one rising edge sample it,
    // return at the following negedge with start/ctrl cleared.
    task automatic launch(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        MDUCtrl = ctrl;
        A       = a;
        B       = b;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        MDUCtrl = MDU_NOP;
    endtask

    // Counts negedges with busy high; returns at the first negedge with busy low.
    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic move_to(input logic [3:0] ctrl, input logic [31:0] val);
        MDUCtrl = ctrl;
        A       = val;
        @(posedge clk);
        @(negedge clk);
        MDUCtrl = MDU_NOP;
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        start = 1'b0;
        MDUCtrl = MDU_NOP;
        MDUResultSel = 1'b0;
        A = 32'd0;
        B = 32'd0;
        reset = 1'b0;

        vecs[0] = '{"mult_neg",    MDU_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{"multu",       MDU_MULTU, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA};
        vecs[2] = '{"div_neg",     MDU_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{"divu",        MDU_DIVU,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003};
        vecs[4] = '{"div_ovf",     MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[5] = '{"mult_min",    MDU_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
        vecs[6] = '{"div_negdivr", MDU_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[7] = '{"multu_max",   MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        vecs[8] = '{"divu_big",    MDU_DIVU,  32'hFFFFFFFF, 32'h00000010, 10, 32'h0000000F, 32'h0FFFFFFF};

        // reset state
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // table of multi-cycle ops
        foreach (vecs[i]) begin
            launch(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            wait_done(n);
            check({vecs[i].name, "_cycles"}, n, vecs[i].cycles);
            check({vecs[i].name, "_hi"}, HI, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, LO, vecs[i].exp_lo);
            MDUResultSel = 1'b1;
            #1 check({vecs[i].name, "_res_hi"}, MDUResult, vecs[i].exp_hi);
            MDUResultSel = 1'b0;
            #1 check({vecs[i].name, "_res_lo"}, MDUResult, vecs[i].exp_lo);
        end

        // MTHI then MFHI next cycle
        move_to(MDU_MTHI, 32'hDEADBEEF);
        MDUResultSel = 1'b1;
        #1 check("mthi_read", MDUResult, 32'hDEADBEEF);

        // divide by zero leaves HI/LO alone; MTLO during busy ignored
        move_to(MDU_MTHI, 32'h11);
        move_to(MDU_MTLO, 32'h22);
        launch(MDU_DIV, 32'd1234, 32'd0);
        check("dz_busy", {31'd0, busy}, 32'd1);
        MDUResultSel = 1'b0;
        #1 check("dz_old_lo", MDUResult, 32'h22);
        move_to(MDU_MTLO, 32'h99);
        check("mtlo_busy_lo", LO, 32'h22);
        wait_done(n);
        check("dz_cycles", n, 32'd9);   // one busy cycle was consumed by move_to
        check("dz_hi", HI, 32'h11);
        check("dz_lo", LO, 32'h22);

        // asynchronous reset during RUN cycle 3
        launch(MDU_MULT, 32'd1000, 32'd1000);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("arst_no_commit_lo", LO, 32'd0);
        launch(MDU_DIV, 32'd100, 32'd7);
        wait_done(n);
        check("post_rst_cycles", n, 32'd10);
        check("post_rst_hi", HI, 32'd2);
        check("post_rst_lo", LO, 32'd14);

        // back-to-back: DIVU launched in the first idle cycle after MULT
        launch(MDU_MULT, 32'd6, 32'd7);
        wait_done(n);
        check("b2b_mult_cycles", n, 32'd5);
        check("b2b_mult_lo", LO, 32'd42);
        check("b2b_mult_hi", HI, 32'd0);
        launch(MDU_DIVU, 32'd100, 32'd9);
        check("b2b_gap_busy", {31'd0, busy}, 32'd1);
        wait_done(n);
        check("b2b_divu_cycles", n, 32'd10);
        check("b2b_divu_hi", HI, 32'd1);
        check("b2b_divu_lo", LO, 32'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multiply/divide unit in the EX stage of the five-stage pipeline. It is fed by the ID/EX register's `start`, `MDUCtrl` and `MDUResultSel` fields and the forwarded rs/rt operands. It holds the architectural HI/LO registers and models fixed multi-cycle latency with a `busy` flag that the hazard unit uses to stall. Its `MDUResult` output is captured by the EX/MEM register.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request for MULT/MULTU/DIV/DIVU; qualified by `MDUCtrl`.
- `MDUCtrl`  in  4  operation code.
- `MDUResultSel`  in  1  selects the read port: 1 = HI, 0 = LO.
- `A`  in  32  rs operand.
- `B`  in  32  rt operand.
- `busy`  out  1  high while an operation is in flight.
- `HI`  out  32  architectural HI.
- `LO`  out  32  architectural LO.
- `MDUResult`  out  32  combinational mux, `MDUResultSel ? HI : LO` (used by MFHI/MFLO).

## Operation
- Ops (`MDUCtrl`): NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; codes 7–15 are treated as NOP.
- States: IDLE and RUN. A down-counter `cnt` of 4 bits or more is sized from max(MULT_CYCLES, DIV_CYCLES).
- IDLE → RUN on an edge where `start`=1 and `MDUCtrl` ∈ {1..4}. On that edge:
  - compute the full result from the current A/B;
  - store it in pending registers `hi_p`/`lo_p`;
  - load `cnt` with the op's cycle count;
  - set `busy`=1.
- RUN: `cnt` decrements each edge. On the edge where `cnt`==1:
  - HI←`hi_p`, LO←`lo_p`;
  - `busy`←0;
  - return to IDLE.
- MULT: {HI,LO} = signed 64-bit product. MULTU: {HI,LO} = unsigned 64-bit product.
- DIV (signed):
  - LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero: the busy window runs normally, but HI/LO are left unchanged at completion.
- MTHI/MTLO: single-edge write of A into HI/LO when in IDLE and not launching. `start` is not required.
- While `busy`=1:
  - `start` is ignored; the hazard unit guarantees it does not occur.
  - MTHI/MTLO are ignored.
  - MDUResult shows the old HI/LO.
- Reset (asserted low, at any time, including mid-RUN):
  - HI=0, LO=0, `busy`=0, `cnt`=0, pending registers = 0, state=IDLE;
  - the in-flight result is discarded.

## Timing
- Launch edge E0 (start sampled). `busy` is high from just after E0 until just after E_N, i.e. for exactly N cycles, where N = MULT_CYCLES or DIV_CYCLES.
- New HI/LO are visible from just after E_N. An MFHI/MFLO in EX in the cycle after `busy` falls reads the new values.
- Back-to-back: a new `start` is accepted in the first cycle with `busy`=0. The edge after that cycle is E0 of the next op; there are no bubbles inside the block.
- MTHI/MTLO take effect at their edge, and are readable through MDUResult in the next cycle.
- MDUResult has zero latency relative to HI/LO/`MDUResultSel`.
- The stall condition `(start || busy) && ID uses MDU` is computed externally. The block only provides `busy`.

## Structure
- Shared package `mdu_pkg` holds:
  - the `MDUCtrl` encodings (MDU_NOP … MDU_MTLO);
  - the default cycle constants.
- Controller and decoder use the same package so the encodings cannot diverge.
- No sub-module. The product/division is combinational inside `mdu_unit` (the latency is modelled, not real). The FSM and counter are inline.

## Test plan
- MULT A=0xFFFFFFFE (-2), B=3, start pulse → `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=-7, B=2 → `busy` high 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7, B=2 → LO=3, HI=1.
- Divide by zero (DIV, B=0) with prior HI=0x11, LO=0x22 → `busy` high 10 cycles; then HI/LO still 0x11/0x22.
- MTHI A=0xDEADBEEF, then MFHI (`MDUResultSel`=1) the next cycle → MDUResult=0xDEADBEEF. MTLO while `busy` → LO unchanged.
- MULT launched, reset pulled low in RUN cycle 3 → `busy`, HI and LO immediately 0 (asynchronous). After release a fresh DIV completes correctly.
- Back-to-back: MULT, then DIVU on the first cycle with `busy`=0 → `busy` stays low for exactly 1 cycle between the two windows. Both results land in sequence.
